// File: rtl/mem_req_if.sv
// Request/response and memory-side bundle for mem_req_ctrl.
// slave: the controller side. master: the requester plus the memory it drives.
interface mem_req_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // Memory port
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_rw, mem_addr, mem_data_in,
        input  mem_data_out, mem_data_valid
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_rw, mem_addr, mem_data_in,
        output mem_data_out, mem_data_valid
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-outstanding request controller in front of a 16x8 memory.
// Sequences writes (one mem_rw=0 cycle) and reads (wait for mem_data_valid,
// bounded by TIMEOUT), and returns exactly one response per request.
// Optional macro MEM_REQ_CTRL_INIT_EN adds a post-reset zero-fill of the memory.
module mem_req_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_req_if.slave bus
);
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP
`ifdef MEM_REQ_CTRL_INIT_EN
        , INIT
`endif
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
    logic              rsp_valid, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata, rsp_rdata_next;
    logic              rsp_err, rsp_err_next;
    logic              mem_rw, mem_rw_next;
    logic [ADDR_W-1:0] mem_addr, mem_addr_next;
    logic [DATA_W-1:0] mem_data_in, mem_data_in_next;

    assign cnt_inc = cnt + CNT_W'(1);

    // Next-state and next-output decode; every registered output is computed here.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_next       = state;
        cnt_next         = cnt;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = rsp_rdata;
        rsp_err_next     = rsp_err;
        mem_rw_next      = 1'b1;
        mem_addr_next    = mem_addr;
        mem_data_in_next = mem_data_in;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    mem_addr_next = bus.req_addr;
                    cnt_next      = '0;
                    if (bus.req_wr) begin
                        state_next       = WRITE;
                        mem_rw_next      = 1'b0;
                        mem_data_in_next = bus.req_wdata;
                    end else begin
                        state_next = READ;
                    end
                end
            end

            WRITE: begin
                state_next     = RESP;
                rsp_err_next   = 1'b0;
                rsp_rdata_next = '0;
            end

            READ: begin
                cnt_next = cnt_inc;
                // The first READ cycle may still see a valid left over from the
                // previous address, so data is only taken from cycle two on.
                // Data has priority over a timeout landing in the same cycle.
                if ((cnt != '0) && bus.mem_data_valid) begin
                    state_next     = RESP;
                    cnt_next       = '0;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = bus.mem_data_out;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_next     = RESP;
                    cnt_next       = '0;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                end
            end

            RESP: begin
                // rsp_valid rises one cycle after entering RESP and drops on the
                // handshake edge, so a held-high rsp_ready sees exactly one beat.
                if (rsp_valid && bus.rsp_ready) begin
                    state_next = IDLE;
                end else begin
                    rsp_valid_next = 1'b1;
                end
            end

`ifdef MEM_REQ_CTRL_INIT_EN
            INIT: begin
                if (cnt == CNT_W'(16)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    mem_rw_next      = 1'b0;
                    mem_addr_next    = cnt[ADDR_W-1:0];
                    mem_data_in_next = '0;
                    cnt_next         = cnt_inc;
                end
            end
`endif

            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset forces mem_rw high at once so no write can slip through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef MEM_REQ_CTRL_INIT_EN
            state       <= INIT;
`else
            state       <= IDLE;
`endif
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mem_rw      <= 1'b1;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            state       <= state_next;
            cnt         <= cnt_next;
            rsp_valid   <= rsp_valid_next;
            rsp_rdata   <= rsp_rdata_next;
            rsp_err     <= rsp_err_next;
            mem_rw      <= mem_rw_next;
            mem_addr    <= mem_addr_next;
            mem_data_in <= mem_data_in_next;
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_rdata   = rsp_rdata;
    assign bus.rsp_err     = rsp_err;
    assign bus.mem_rw      = mem_rw;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_data_in = mem_data_in;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural 16x8 memory model.
// Honours MEM_REQ_CTRL_INIT_EN when it is defined for the build.
module tb_mem_req_ctrl;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;
`ifdef MEM_REQ_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic dv_auto;
    logic dv_manual;
    logic dv_model = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   init_addr = 0;

    logic [DATA_W-1:0] mem_model [16] = '{default: (INIT_EN ? 8'hEE : 8'h00)};

    mem_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory: writes when rw=0, registered read with data_valid one cycle after a read address.
    always @(posedge clk) begin
        if (bus.mem_rw == 1'b0) mem_model[bus.mem_addr] <= bus.mem_data_in;
        bus.mem_data_out <= mem_model[bus.mem_addr];
        dv_model         <= bus.mem_rw;
    end

    assign bus.mem_data_valid = dv_auto ? dv_model : dv_manual;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        check("wr_req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        step();
        bus.req_valid = 1'b0;
        check("wr_mem_rw_low", bus.mem_rw, 0);
        check("wr_mem_addr", bus.mem_addr, 32'(a));
        check("wr_mem_data_in", bus.mem_data_in, 32'(d));
        check("wr_req_ready_busy", bus.req_ready, 0);
        check("wr_rsp_valid_early", bus.rsp_valid, 0);
        step();
        check("wr_mem_rw_back", bus.mem_rw, 1);
        check("wr_rsp_valid_gap", bus.rsp_valid, 0);
        step();
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_err", bus.rsp_err, 0);
        check("wr_rsp_rdata", bus.rsp_rdata, 0);
        step();
        check("wr_rsp_valid_drop", bus.rsp_valid, 0);
        check("wr_req_ready_back", bus.req_ready, 1);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_d);
        check("rd_req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = 8'h77;
        step();
        bus.req_valid = 1'b0;
        check("rd_mem_rw", bus.mem_rw, 1);
        check("rd_mem_addr", bus.mem_addr, 32'(a));
        step();
        check("rd_rsp_valid_c1", bus.rsp_valid, 0);
        step();
        check("rd_rsp_valid_c2", bus.rsp_valid, 0);
        step();
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_err", bus.rsp_err, 0);
        check("rd_rsp_rdata", bus.rsp_rdata, 32'(exp_d));
        step();
        check("rd_rsp_valid_drop", bus.rsp_valid, 0);
        check("rd_req_ready_back", bus.req_ready, 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        dv_auto       = 1'b1;
        dv_manual     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset values
        #12;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_mem_rw", bus.mem_rw, 1);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_data_in", bus.mem_data_in, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_req_ready", bus.req_ready, INIT_EN ? 0 : 1);

        // Zero-fill sequence, then every location reads back 0
        if (INIT_EN) begin
            for (int i = 0; i < 40 && bus.req_ready !== 1'b1; i++) begin
                step();
                if (bus.mem_rw === 1'b0) begin
                    check("init_addr", bus.mem_addr, 32'(init_addr));
                    check("init_data", bus.mem_data_in, 0);
                    check("init_req_ready", bus.req_ready, 0);
                    init_addr++;
                end
            end
            check("init_cycles", 32'(init_addr), 16);
            check("init_done_ready", bus.req_ready, 1);
            for (int a = 0; a < 16; a++) do_read(4'(a), 8'h00);
        end

        // Basic write then read-back
        do_write(4'd3, 8'hA5);
        do_read(4'd3, 8'hA5);

        // Address extremes; each read follows a different address so the stale valid is exercised
        do_write(4'd15, 8'h3C);
        do_write(4'd0, 8'hC3);
        do_read(4'd15, 8'h3C);
        do_read(4'd0, 8'hC3);

        // Read timeout with response back-pressure
        dv_auto       = 1'b0;
        dv_manual     = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 4'd5;
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            check("to_rsp_valid_wait", bus.rsp_valid, 0);
            check("to_mem_rw", bus.mem_rw, 1);
        end
        step();
        check("to_rsp_valid", bus.rsp_valid, 1);
        check("to_rsp_err", bus.rsp_err, 1);
        check("to_rsp_rdata", bus.rsp_rdata, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_err", bus.rsp_err, 1);
            check("hold_rsp_rdata", bus.rsp_rdata, 0);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        step();
        check("hold_rsp_valid_drop", bus.rsp_valid, 0);
        check("hold_req_ready_back", bus.req_ready, 1);

        // Data arrives in the same cycle the counter reaches TIMEOUT: data wins
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 4'd3;
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) step();
        dv_manual = 1'b1;
        step();
        dv_manual = 1'b0;
        check("race_rsp_valid_wait", bus.rsp_valid, 0);
        step();
        check("race_rsp_valid", bus.rsp_valid, 1);
        check("race_rsp_err", bus.rsp_err, 0);
        check("race_rsp_rdata", bus.rsp_rdata, 32'hA5);
        step();
        check("race_rsp_valid_drop", bus.rsp_valid, 0);
        dv_auto = 1'b1;

        // Reset in the middle of a write aborts it
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 4'd7;
        bus.req_wdata = 8'h99;
        step();
        bus.req_valid = 1'b0;
        check("abort_mem_rw_low", bus.mem_rw, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_mem_rw", bus.mem_rw, 1);
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_mem_data_in", bus.mem_data_in, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_rsp_err", bus.rsp_err, 0);
        check("abort_rsp_rdata", bus.rsp_rdata, 0);
        check("abort_req_ready", bus.req_ready, INIT_EN ? 0 : 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_no_write", 32'(mem_model[7]), 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("abort_no_rsp", bus.rsp_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request controller directly upstream of the 16x8 memory unit: it is the only block driving the memory's `rw`, `addr` and `data_in`. It accepts one write or read request at a time over a valid/ready handshake, sequences the memory access and waits for the memory's `data_valid` on reads. It returns exactly one response per request over a second valid/ready handshake, with an error flag on read timeout.

## Interface
- `ADDR_W`, 4, memory address width (16 locations)
- `DATA_W`, 8, data width
- `TIMEOUT`, 15, maximum cycles a read waits for `mem_data_valid` before erroring (range 1..255)

- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: controller can accept a request
- `req_wr` in 1: 1 = write, 0 = read
- `req_addr` in ADDR_W: target location
- `req_wdata` in DATA_W: write data, ignored on reads
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: consumer takes the response
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors
- `rsp_err` out 1: read timed out
- `mem_rw` out 1: to memory `rw`; 0 = write, 1 = read
- `mem_addr` out ADDR_W: to memory `addr`
- `mem_data_in` out DATA_W: to memory `data_in`
- `mem_data_out` in DATA_W: from memory `data_out`
- `mem_data_valid` in 1: from memory `data_valid`

## Operation
- The memory writes on every rising edge where `mem_rw`=0. `mem_rw` is therefore 1 in every state except WRITE and INIT.
- All outputs are registered except `req_ready`, which is `state==IDLE`.
- States and transitions:
  - IDLE: when `req_valid`&&`req_ready`, capture addr, wdata and wr. Go to WRITE if wr=1, otherwise READ.
  - WRITE: drive `mem_rw`=0, `mem_addr`=addr, `mem_data_in`=wdata for exactly one cycle. Then go to RESP with `rsp_err`=0 and `rsp_rdata`=0.
  - READ: drive `mem_rw`=1 and `mem_addr`=addr; the cycle counter starts at 0.
    - `mem_data_valid` is ignored in the first READ cycle, which guards against a stale valid from a previous address.
    - From the second cycle on, `mem_data_valid`=1 captures `mem_data_out` into `rsp_rdata` and goes to RESP with `rsp_err`=0.
    - If the counter reaches TIMEOUT, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - RESP: hold `rsp_valid`=1 and a stable payload until `rsp_ready`=1, then return to IDLE.
- Only one request is outstanding at a time; no new request is accepted while in WRITE, READ or RESP.
- `mem_data_in` holds its last value outside WRITE.
- `mem_addr` holds its last value.

## Timing
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_rw`=1, `mem_addr`=0, `mem_data_in`=0, counter 0. The state is IDLE, or INIT when `MEM_REQ_CTRL_INIT_EN` is defined.
- Write latency: request accepted at edge N, WRITE during cycle N..N+1, `rsp_valid` high after edge N+2.
- Read latency:
  - Minimum: `rsp_valid` high after edge N+3, when `mem_data_valid` is high in the second READ cycle.
  - Maximum: `rsp_valid` high after edge N+1+TIMEOUT.
- Response handshake: completes in the cycle where `rsp_valid`&&`rsp_ready`. `req_ready` rises in the following cycle; there is no back-to-back accept in the handshake cycle.
- Boundary conditions:
  - `rsp_ready` held high: one response per request, with no response dropped or duplicated.
  - `mem_data_valid` arriving in the same cycle the counter hits TIMEOUT: data wins, `rsp_err`=0.
  - Address 15 and address 0 behave identically; there is no wrap logic.
  - Asserting `rst_n` mid-operation aborts immediately. `mem_rw` returns to 1 asynchronously, so no partial write occurs after reset, and any pending response is lost.

## Configuration
- Macro: `MEM_REQ_CTRL_INIT_EN`.
- Defined:
  - After reset, the controller enters INIT and zero-fills the memory with `mem_rw`=0 and `mem_data_in`=0, with `mem_addr` stepping 0..15 one location per cycle.
  - INIT lasts 16 cycles, then goes to IDLE.
  - `req_ready`=0 throughout INIT.
- Undefined: the INIT state and its logic are absent. The controller enters IDLE at reset, so `req_ready`=1 on the first cycle after reset release.

## Test plan
- Write addr 3 data 0xA5 with `rsp_ready`=1 -> `mem_rw`=0 for exactly one cycle with addr 3 and data 0xA5; `rsp_valid` one cycle later with err=0 and rdata=0.
- Write addr 3 0xA5, then read addr 3, with the memory model asserting valid one cycle after the address -> `rsp_rdata`=0xA5, err=0, `rsp_valid` 3 cycles after accept.
- Read with `mem_data_valid` held 0 and TIMEOUT=15 -> `rsp_valid` 16 cycles after accept with err=1 and rdata=0; `mem_rw` never 0.
- Hold `rsp_ready`=0 for 5 cycles during RESP -> `rsp_valid` and payload stable; `req_ready`=0 until one cycle after the handshake.
- Assert `rst_n`=0 during WRITE -> `mem_rw`=1 immediately, all outputs at their reset values, no response after release.
- With `MEM_REQ_CTRL_INIT_EN` defined, release reset -> 16 cycles with `mem_rw`=0 and addr 0..15, `req_ready`=0; afterwards reads of addresses 0..15 all return 0x00.
